key_event_queue: RTL and testbench
==================================

# key_event_queue

Downstream consumer of the 4x4 keypad scanner's 16-bit `keys` vector. It debounces the vector as a whole and detects per-key press and release edges. Each edge becomes a 5-bit event in a small FIFO with valid/ready handshake. Game/menu control logic pops events from the FIFO instead of polling key levels.

## Interface
- `DEBOUNCE_CNT`, default 500000: cycles `keys` must hold unchanged before it is accepted as stable (5 ms at 100 MHz); legal range 1..2^20.
- `FIFO_DEPTH`, default 4: event FIFO entries; power of two, at least 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `keys`  in  16  raw key levels from the scanner, bit i = 1 while key code i is pressed.
- `stable_keys`  out  16  debounced key levels.
- `ev_valid`  out  1  FIFO non-empty.
- `ev_ready`  in  1  consumer accepts the head event.
- `ev_data`  out  5  head event {press, code[3:0]}; press = 1 for press, 0 for release.
- `ev_count`  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky flag: an edge was merged into an already-pending edge.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- Debounce registers: `cand[15:0]`, `cnt[19:0]`, `stable[15:0]`.
  - If `keys != cand`: `cand <= keys`, `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CNT-1`: `stable <= cand`, and `cnt` holds.
  - Otherwise `cnt <= cnt+1`.
- Edge capture happens in the same cycle that `stable` loads:
  - `pend_p |= cand & ~stable`
  - `pend_r |= ~cand & stable`
  - If a newly detected edge bit is already set in the corresponding pending mask, set `overflow`.
- Arbitration, one push per cycle, no FSM beyond this priority:
  - Press before release.
  - Within a class, the lowest set index wins.
  - The winner's pending bit clears on the cycle the push occurs.
- Push condition: `count < FIFO_DEPTH`, or a pop happens in the same cycle.
  - While the FIFO is full with no pop, pending bits are held. Events are never dropped, only merged.
- A pending bit that is cleared by a push and set by a new edge in the same cycle ends up set.
- FIFO behaviour:
  - Show-ahead: `ev_data` is the head entry whenever `ev_valid` = 1.
  - Pop on `ev_valid & ev_ready`.
  - `ev_data` is don't-care while `ev_valid` = 0.
- `ovf_clr`: clears `overflow`. A set event in the same cycle wins.
- Reset values: `cand`, `stable`, `pend_p`, `pend_r`, `cnt` = 0; FIFO empty; `ev_valid` = 0; `ev_count` = 0; `overflow` = 0; `stable_keys` = 0. Reset mid-operation discards all pending and queued events.
- Keys held through reset produce press events after the debounce period, because `stable` restarts at 0.

## Timing
- Let E0 be the edge at which `keys` first differs from `cand`.
  - E0: `cand` loads.
  - E_D (D = DEBOUNCE_CNT): `stable` loads and pending bits set.
  - E_{D+1}: first push.
  - `ev_valid` is high after E_{D+1}.
- Any `keys` change before E_D restarts the count from the changing edge.
- n simultaneous edges enter the FIFO one per cycle, over n consecutive edges, while space remains.
- Pop-to-next-head: 0 cycles. The next entry is visible immediately after the pop edge.
- Debounce uses only the scanner's settled `keys`. Scanner refresh glitches shorter than D cycles are absorbed.

## Structure
- Package `key_pkg`:
  - `KEY_W` = 16 and `EV_W` = 5.
  - Event bit positions: `EV_PRESS_BIT` = 4, code [3:0].
  - A function returning the lowest-set index of a 16-bit mask.
- Sub-module `key_event_fifo`: a synchronous show-ahead FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, din, full, pop, dout, empty, count.
  - Pointer wrap modulo DEPTH.
- Debounce, edge capture and arbitration live in `key_event_queue`.

## Test plan
- DEBOUNCE_CNT=4; `keys` 0 -> 16'h0020 held -> `stable_keys` = 16'h0020 after E4; `ev_valid` high after E5 with `ev_data` = 5'h15; `ev_ready`=1 pops; FIFO empties.
- `keys` = 16'h0020 for 3 cycles, then 0, repeated (bounce) -> no event, `stable_keys` stays 0.
- Keys 3, 9 and 12 pressed simultaneously with `ev_ready`=0 -> FIFO holds 5'h13, 5'h19, 5'h1C in that order; `ev_count` = 3.
- `ev_ready`=0; press 5 keys; release all -> FIFO full (4), remaining press and releases pending; then `ev_ready`=1 -> every press emitted before any release, none lost; `overflow` = 0.
- Press/release key 0 twice while FIFO full and its press still pending -> `overflow` = 1; `ovf_clr` pulse -> 0.
- Mid-debounce and with FIFO holding 2 events, assert `rst` one cycle -> all outputs at reset values the next cycle; held key produces a press event D+1 cycles after `rst` deasserts.

Source files
------------

// File: rtl/key_pkg.sv
// Shared widths, event layout and helpers for the keypad event queue.
// Imported by the queue top and its event FIFO.
package key_pkg;

  localparam int KEY_W        = 16;
  localparam int EV_W         = 5;
  localparam int CODE_W       = 4;
  localparam int EV_PRESS_BIT = 4;
  localparam int CNT_W        = 20;

  typedef logic [KEY_W-1:0] key_t;

  typedef struct packed {
    logic              press;
    logic [CODE_W-1:0] code;
  } ev_t;

  function automatic logic [CODE_W-1:0] lowest_idx(
    input logic [KEY_W-1:0] m
  );
    lowest_idx = '0;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous show-ahead FIFO; pop of the head and push into the freed
// slot may share a cycle even when full.
module key_event_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign count  = r_cnt;
  assign dout   = r_mem[r_rp];
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end

endmodule

// File: rtl/key_event_queue.sv
// Debounces the scanner's key vector, turns per-key edges into press and
// release events, and queues them for the game/menu logic.
module key_event_queue
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 500000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [KEY_W-1:0]              keys,
  output logic [KEY_W-1:0]              stable_keys,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [EV_W-1:0]               ev_data,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CNT - 1);

  key_t             r_cand;
  key_t             r_stable;
  key_t             r_pend_p;
  key_t             r_pend_r;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_same;
  logic             w_load;
  key_t             w_new_p;
  key_t             w_new_r;
  logic             w_ovf_set;
  logic             w_sel_p;
  logic             w_req;
  logic [CODE_W-1:0] w_code;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  key_t             w_clr_p;
  key_t             w_clr_r;
  ev_t              w_din;

  assign w_same = (keys == r_cand);
  assign w_load = w_same && (r_cnt == LAST);

  always_comb begin
    w_new_p = '0;
    w_new_r = '0;
    if (w_load) begin
      w_new_p = r_cand & ~r_stable;
      w_new_r = ~r_cand & r_stable;
    end
  end

  assign w_ovf_set = |(w_new_p & r_pend_p) | |(w_new_r & r_pend_r);

  // Presses outrank releases; lowest code wins within a class.
  assign w_sel_p = |r_pend_p;
  assign w_req   = w_sel_p | (|r_pend_r);
  assign w_code  = lowest_idx(w_sel_p ? r_pend_p : r_pend_r);
  assign w_pop   = ev_valid & ev_ready;
  assign w_push  = w_req & (~w_full | w_pop);

  always_comb begin
    w_clr_p = '0;
    w_clr_r = '0;
    if (w_push) begin
      if (w_sel_p) w_clr_p = KEY_W'(1) << w_code;
      else         w_clr_r = KEY_W'(1) << w_code;
    end
  end

  assign w_din.press = w_sel_p;
  assign w_din.code  = w_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
      r_pend_p <= '0;
      r_pend_r <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (!w_same) begin
        r_cand <= keys;
        r_cnt  <= '0;
      end else if (w_load) begin
        r_stable <= r_cand;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // A fresh edge re-arms a bit even if its push clears it this cycle.
      r_pend_p <= (r_pend_p & ~w_clr_p) | w_new_p;
      r_pend_r <= (r_pend_r & ~w_clr_r) | w_new_r;
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  key_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_din),
    .full  (w_full),
    .pop   (w_pop),
    .dout  (ev_data),
    .empty (w_empty),
    .count (ev_count)
  );

  assign ev_valid    = ~w_empty;
  assign stable_keys = r_stable;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based model.
module tb_key_event_queue;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;
  logic [15:0] stable_keys;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [4:0]  ev_data;
  logic [2:0]  ev_count;
  logic        overflow;
  logic        ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  key_event_queue #(
    .DEBOUNCE_CNT (D),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .keys        (keys),
    .stable_keys (stable_keys),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_data     (ev_data),
    .ev_count    (ev_count),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model: stable accepts keys once the last D+1 samples agree (the reset
  // edge counts as one zero sample); edges land in pending sets; events
  // leave one per cycle into a plain queue.
  bit [15:0] m_hist[$];
  bit [15:0] m_stable, m_pp, m_pr;
  bit        m_ovf;
  bit [4:0]  m_q[$];
  bit        m_init = 1'b0;
  bit [15:0] m_np, m_nr;
  bit        m_pop, m_have, m_eq;
  bit [4:0]  m_ev;

  always @(posedge clk) begin
    if (rst) begin
      m_hist.delete();
      m_hist.push_back(16'h0);
      m_stable = '0;
      m_pp = '0;
      m_pr = '0;
      m_ovf = 1'b0;
      m_q.delete();
      m_init = 1'b1;
    end else if (m_init) begin
      m_hist.push_back(keys);
      if (m_hist.size() > D + 1) void'(m_hist.pop_front());
      m_np = '0;
      m_nr = '0;
      m_eq = (m_hist.size() == D + 1);
      foreach (m_hist[i]) if (m_hist[i] != keys) m_eq = 1'b0;
      if (m_eq) begin
        m_np = keys & ~m_stable;
        m_nr = ~keys & m_stable;
        m_stable = keys;
      end
      if (((m_np & m_pp) | (m_nr & m_pr)) != 0) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_pop = (m_q.size() > 0) && ev_ready;
      m_have = 1'b0;
      m_ev = '0;
      for (int i = 0; i < 16; i++)
        if (!m_have && m_pp[i]) begin
          m_have = 1'b1;
          m_ev = {1'b1, 4'(i)};
        end
      for (int i = 0; i < 16; i++)
        if (!m_have && m_pr[i]) begin
          m_have = 1'b1;
          m_ev = {1'b0, 4'(i)};
        end
      if (m_pop) void'(m_q.pop_front());
      if (m_have && (m_q.size() < DEPTH)) begin
        m_q.push_back(m_ev);
        if (m_ev[4]) m_pp[m_ev[3:0]] = 1'b0;
        else         m_pr[m_ev[3:0]] = 1'b0;
      end
      m_pp |= m_np;
      m_pr |= m_nr;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("stable_keys", int'(stable_keys), int'(m_stable));
      chk("ev_valid", int'(ev_valid), int'(m_q.size() > 0));
      chk("ev_count", int'(ev_count), m_q.size());
      chk("overflow", int'(overflow), int'(m_ovf));
      if (m_q.size() > 0) chk("ev_data", int'(ev_data), int'(m_q[0]));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  bit [4:0] exp4 [10];
  int       r;

  initial begin
    exp4 = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h14,
             5'h00, 5'h01, 5'h02, 5'h03, 5'h04};

    step(1);
    rst = 1'b0;
    chk("rst_stable", int'(stable_keys), 0);
    chk("rst_valid", int'(ev_valid), 0);
    chk("rst_count", int'(ev_count), 0);
    chk("rst_ovf", int'(overflow), 0);

    // single press, debounce latency, pop
    keys = 16'h0020;
    step(5);
    chk("t1_stable", int'(stable_keys), 16'h0020);
    chk("t1_valid_early", int'(ev_valid), 0);
    step(1);
    chk("t1_valid", int'(ev_valid), 1);
    chk("t1_data", int'(ev_data), 5'h15);
    ev_ready = 1'b1;
    step(1);
    chk("t1_empty", int'(ev_valid), 0);
    keys = '0;
    step(8);
    ev_ready = 1'b0;

    // bounce shorter than the debounce window
    for (int k = 0; k < 4; k++) begin
      keys = 16'h0020;
      step(3);
      keys = '0;
      step(3);
    end
    chk("t2_stable", int'(stable_keys), 0);
    chk("t2_valid", int'(ev_valid), 0);

    // simultaneous presses queue lowest code first
    step(8);
    keys = 16'h1208;
    step(8);
    chk("t3_count", int'(ev_count), 3);
    chk("t3_head0", int'(ev_data), 5'h13);
    ev_ready = 1'b1;
    step(1);
    chk("t3_head1", int'(ev_data), 5'h19);
    step(1);
    chk("t3_head2", int'(ev_data), 5'h1C);
    step(1);
    chk("t3_empty", int'(ev_valid), 0);
    keys = '0;
    step(10);
    ev_ready = 1'b0;

    // full FIFO: presses drain before releases, nothing lost
    keys = 16'h001F;
    step(10);
    keys = '0;
    step(10);
    chk("t4_full", int'(ev_count), 4);
    chk("t4_ovf", int'(overflow), 0);
    ev_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t4_order", int'(ev_data), int'(exp4[i]));
      step(1);
    end
    chk("t4_empty", int'(ev_valid), 0);
    chk("t4_ovf_end", int'(overflow), 0);
    ev_ready = 1'b0;

    // merged edge while full sets the sticky flag
    keys = 16'h001E;
    step(10);
    keys = 16'h001F;
    step(10);
    keys = 16'h001E;
    step(10);
    chk("t5_noovf", int'(overflow), 0);
    keys = 16'h001F;
    step(10);
    chk("t5_ovf", int'(overflow), 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("t5_clr", int'(overflow), 0);

    // reset mid-debounce with queued events
    ev_ready = 1'b1;
    keys = '0;
    step(20);
    ev_ready = 1'b0;
    keys = 16'h0003;
    step(8);
    chk("t6_pre", int'(ev_count), 2);
    keys = 16'h0103;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6_stable", int'(stable_keys), 0);
    chk("t6_valid", int'(ev_valid), 0);
    chk("t6_count", int'(ev_count), 0);
    chk("t6_ovf", int'(overflow), 0);
    step(5);
    chk("t6_wait", int'(ev_valid), 0);
    step(1);
    chk("t6_valid2", int'(ev_valid), 1);
    chk("t6_data", int'(ev_data), 5'h10);
    chk("t6_count2", int'(ev_count), 1);

    // randomized traffic, model compared every cycle
    for (int c = 0; c < 4000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6)       keys = keys ^ (16'(1) << $urandom_range(0, 15));
      else if (r < 8)  keys = 16'($urandom);
      else if (r < 10) keys = keys & 16'($urandom);
      if ((c % 400) < 150) ev_ready = 1'b0;
      else ev_ready = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 599) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
